// File: rtl/cam_capture.sv
// Camera capture: OV7670-style byte stream -> RGB565 frame-buffer writes with frame framing/error flags.
// Latency: we asserted 2 pclk cycles after the pixel's second byte is presented on cam_data.
// Backpressure: none; the camera cannot be stalled, so malformed pixels are dropped and flagged.
module cam_capture #(
    parameter int W = 320,
    parameter int H = 240
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    output logic        we,
    output logic [16:0] wAddr,
    output logic [15:0] wData,
    output logic        frame_start,
    output logic        frame_done,
    output logic        sync_err,
    output logic [7:0]  frame_cnt
);

    localparam int XW = $clog2(W + 1);
    localparam int LW = $clog2(H + 2);
    localparam logic [XW-1:0] W_X   = XW'(W);
    localparam logic [LW-1:0] H_L   = LW'(H);
    localparam logic [16:0]   W_ROW = 17'(W);

    typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} state_t;

    state_t        state;
    logic          v_q, h_q, v_qq, h_qq;
    logic [7:0]    d_q, hi_byte;
    logic          phase;
    logic [XW-1:0] x;
    logic [LW-1:0] line;
    logic [16:0]   row_base;

    logic          active, h_rise, h_fall, v_rise, v_fall;
    logic          cur_phase, phase_after, pix_done, in_x, in_line;
    logic          close_line, has_px, err_now;
    logic [XW-1:0] x_after;
    logic [LW-1:0] line_after;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            v_q  <= 1'b0;
            h_q  <= 1'b0;
            d_q  <= '0;
            v_qq <= 1'b0;
            h_qq <= 1'b0;
        end else begin
            v_q  <= cam_vsync;
            h_q  <= cam_href;
            d_q  <= cam_data;
            v_qq <= v_q;
            h_qq <= h_q;
        end
    end

    always_comb begin
        active      = (state == ACTIVE);
        h_rise      = h_q & ~h_qq;
        h_fall      = ~h_q & h_qq;
        v_rise      = v_q & ~v_qq;
        v_fall      = ~v_q & v_qq;
        cur_phase   = phase & ~h_rise;
        phase_after = h_q ? ~cur_phase : phase;
        pix_done    = active & h_q & cur_phase;
        in_x        = (x < W_X);
        in_line     = (line < H_L);
        x_after     = x + XW'(pix_done & in_x);
        // A vsync rise while href is still high closes the line before the line-count check.
        close_line  = active & (h_fall | (v_rise & h_q));
        has_px      = (x_after != '0);
        line_after  = (close_line && has_px && line <= H_L) ? line + 1'b1 : line;
        err_now     = (pix_done & ~(in_x & in_line))
                    | (close_line & ((has_px & (x_after != W_X)) | phase_after))
                    | (active & v_rise & (line_after != H_L));
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            we          <= 1'b0;
            wAddr       <= '0;
            wData       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            frame_cnt   <= '0;
            hi_byte     <= '0;
            phase       <= 1'b0;
            x           <= '0;
            line        <= '0;
            row_base    <= '0;
        end else begin
            we          <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                SYNC: begin
                    if (v_q) state <= BLANK;
                end
                BLANK: begin
                    if (v_fall && capture_en) begin
                        state       <= ACTIVE;
                        frame_start <= 1'b1;
                        sync_err    <= 1'b0;
                        line        <= '0;
                        row_base    <= '0;
                        x           <= '0;
                        phase       <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (h_q && !cur_phase) hi_byte <= d_q;
                    if (pix_done && in_x && in_line) begin
                        we    <= 1'b1;
                        wAddr <= row_base + 17'(x);
                        wData <= {hi_byte, d_q};
                    end
                    phase <= phase_after;
                    x     <= close_line ? '0 : x_after;
                    line  <= line_after;
                    if (close_line && has_px && in_line) row_base <= row_base + W_ROW;
                    if (err_now) sync_err <= 1'b1;
                    if (v_rise) begin
                        state      <= BLANK;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Randomized frame stimulus; expected writes and frame results are queued by the driver and checked by a monitor.
module tb_cam_capture;

    localparam int W = 4;
    localparam int H = 3;

    logic        pclk = 1'b0;
    logic        reset_n, cam_vsync, cam_href, capture_en;
    logic [7:0]  cam_data;
    logic        we, frame_start, frame_done, sync_err;
    logic [16:0] wAddr;
    logic [15:0] wData;
    logic [7:0]  frame_cnt;

    cam_capture #(.W(W), .H(H)) dut (
        .pclk(pclk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .we(we), .wAddr(wAddr), .wData(wData),
        .frame_start(frame_start), .frame_done(frame_done), .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wexp_t;
    typedef struct { bit err; int cnt; } fexp_t;

    wexp_t wq[$];
    fexp_t fq[$];
    wexp_t me;
    fexp_t mf;
    int checks = 0, failures = 0;
    int starts_exp = 0, starts_seen = 0, we_seen = 0;
    int cnt_model = 0, captured = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({we, frame_start, frame_done, sync_err} == 4'b0, {nm, "_flags"},
            int'({we, frame_start, frame_done, sync_err}), 0);
        chk(wAddr == 0, {nm, "_waddr"}, int'(wAddr), 0);
        chk(wData == 0, {nm, "_wdata"}, int'(wData), 0);
        chk(frame_cnt == 0, {nm, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    // Drives nb bytes of one line; li is the index among non-empty lines of the frame.
    task automatic send_line(input int nb, input int li, input bit exp_wr, input bit fixed);
        logic [7:0] hi, b8;
        wexp_t e;
        hi = 8'h00;
        for (int b = 0; b < nb; b++) begin
            b8 = fixed ? ((b % 2 == 0) ? 8'h12 : 8'h34) : 8'($urandom);
            cam_href = 1'b1;
            cam_data = b8;
            if (b % 2 == 0) hi = b8;
            else if (exp_wr && li < H && b / 2 < W) begin
                e.addr = li * W + b / 2;
                e.data = int'({hi, b8});
                e.cyc  = cyc + 2;
                wq.push_back(e);
            end
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'($urandom);
    endtask

    task automatic do_frame(input bit en, input bit fixed, input int nlines, input int bp[4]);
        int li;
        bit err;
        fexp_t f;
        capture_en = en;
        cam_vsync  = 1'b1;
        cam_href   = 1'b0;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
        li  = 0;
        err = 1'b0;
        for (int l = 0; l < nlines; l++) begin
            send_line(bp[l], li, en, fixed);
            if (!fixed) capture_en = 1'($urandom_range(0, 1));
            if (bp[l] >= 2) begin
                if ((bp[l] % 2) != 0 || bp[l] / 2 != W || li >= H) err = 1'b1;
                li++;
            end
            repeat ($urandom_range(1, 3)) tick();
        end
        if (li != H) err = 1'b1;
        if (en) begin
            cnt_model = (cnt_model + 1) % 256;
            f.err = err;
            f.cnt = cnt_model;
            fq.push_back(f);
            starts_exp++;
            captured++;
        end
    endtask

    function automatic int rand_bytes();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return 2 * W;
        if (r == 6) return 2 * W + 2;
        if (r == 7) return 2 * W - 1;
        if (r == 8) return 2 * W + 1;
        return 2 * W - 2;
    endfunction

    initial begin
        forever begin
            @(negedge pclk);
            if (reset_n) begin
                if (we) begin
                    we_seen++;
                    if (wq.size() == 0) chk(1'b0, "we_unexpected", int'(wAddr), -1);
                    else begin
                        me = wq.pop_front();
                        chk(wAddr == 17'(me.addr), "waddr", int'(wAddr), me.addr);
                        chk(wData == 16'(me.data), "wdata", int'(wData), me.data);
                        chk(cyc == me.cyc, "we_cycle", cyc, me.cyc);
                    end
                end
                if (frame_start) begin
                    starts_seen++;
                    chk(sync_err == 1'b0, "err_clear_at_start", int'(sync_err), 0);
                end
                if (frame_done) begin
                    if (fq.size() == 0) chk(1'b0, "done_unexpected", int'(frame_cnt), -1);
                    else begin
                        mf = fq.pop_front();
                        chk(sync_err == mf.err, "sync_err_at_done", int'(sync_err), int'(mf.err));
                        chk(frame_cnt == 8'(mf.cnt), "frame_cnt", int'(frame_cnt), mf.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int bp[4];
        int nl, r, guard;
        reset_n    = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b0;
        cam_data   = 8'h00;
        capture_en = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Lines arriving mid-frame after reset must be discarded.
        send_line(8, 0, 1'b0, 1'b1);
        repeat (2) tick();
        send_line(8, 1, 1'b0, 1'b0);
        repeat (3) tick();
        chk(we_seen == 0, "no_we_before_sync", we_seen, 0);
        chk(starts_seen == 0, "no_start_before_sync", starts_seen, 0);

        do_frame(1'b1, 1'b1, 3, '{8, 8, 8, 0});
        do_frame(1'b1, 1'b0, 3, '{10, 8, 8, 0});
        do_frame(1'b1, 1'b0, 3, '{8, 7, 8, 0});
        do_frame(1'b1, 1'b0, 2, '{8, 8, 0, 0});
        do_frame(1'b0, 1'b0, 3, '{8, 8, 8, 0});
        do_frame(1'b1, 1'b0, 3, '{8, 8, 8, 0});

        guard = 0;
        while (captured < 270 && guard < 600) begin
            r  = $urandom_range(0, 9);
            nl = (r <= 7) ? H : ((r == 8) ? H - 1 : H + 1);
            for (int i = 0; i < 4; i++) bp[i] = rand_bytes();
            do_frame($urandom_range(0, 9) != 0, 1'b0, nl, bp);
            guard++;
        end
        chk(captured >= 256, "enough_frames_for_wrap", captured, 256);

        // Reset during line 1 of a captured frame.
        capture_en = 1'b1;
        cam_vsync  = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
        starts_exp++;
        send_line(8, 0, 1'b1, 1'b1);
        repeat (2) tick();
        cam_href = 1'b1;
        cam_data = 8'h55;
        tick();
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        chk(wq.size() == 0, "writes_before_reset", wq.size(), 0);
        cnt_model = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        send_line(7, 1, 1'b0, 1'b0);
        repeat (2) tick();
        send_line(8, 2, 1'b0, 1'b0);
        repeat (2) tick();
        do_frame(1'b1, 1'b1, 3, '{8, 8, 8, 0});

        cam_vsync = 1'b1;
        repeat (8) tick();
        chk(wq.size() == 0, "pending_writes", wq.size(), 0);
        chk(fq.size() == 0, "pending_frames", fq.size(), 0);
        chk(starts_seen == starts_exp, "frame_start_count", starts_seen, starts_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
